// File: rtl/core_pkg.sv
// Shared core types: next-PC select encoding (also used by the control unit),
// fetch state encoding and the opcode field width.
package core_pkg;

    localparam int OPCODE_W = 7;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JAL    = 2'b10,
        NPC_JALR   = 2'b11
    } nextpc_sel_e;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'b00,
        FS_REQ   = 2'b01,
        FS_WAIT  = 2'b10,
        FS_VALID = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/fetch_target_calc.sv
// Redirect resolution: decides whether execute's control-flow result
// redirects fetch, and produces the word-aligned target plus misalign flag.
module fetch_target_calc
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            redirect_valid,
    input  logic [1:0]      nextpc_sel,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] pc_ex,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    logic [XLEN-1:0] raw_target;

    always_comb begin
        taken      = 1'b0;
        raw_target = pc_ex + imm;
        case (nextpc_sel_e'(nextpc_sel))
            NPC_BRANCH: taken = redirect_valid & branch_taken;
            NPC_JAL:    taken = redirect_valid;
            NPC_JALR: begin
                taken      = redirect_valid;
                raw_target = (rs1 + imm) & ~XLEN'(1);
            end
            default:    taken = 1'b0;
        endcase
        // A halfword-aligned target is flagged but fetch still proceeds on the word.
        misalign = taken & raw_target[1];
        target   = raw_target & ~XLEN'(3);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem transaction in flight
// and hands registered instructions to decode over valid/ready.
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    output logic                imem_req_o,
    output logic [XLEN-1:0]     imem_addr_o,
    input  logic                imem_gnt_i,
    input  logic                imem_rvalid_i,
    input  logic [31:0]         imem_rdata_i,
    output logic                instr_valid_o,
    input  logic                instr_ready_i,
    output logic [31:0]         instr_o,
    output logic [OPCODE_W-1:0] opcode_o,
    output logic [XLEN-1:0]     pc_o,
    input  logic                redirect_valid_i,
    input  logic [1:0]          nextpc_sel_i,
    input  logic                branch_taken_i,
    input  logic [XLEN-1:0]     pc_ex_i,
    input  logic [XLEN-1:0]     imm_i,
    input  logic [XLEN-1:0]     rs1_i,
    output logic                misalign_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            capture;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_out_q;
    logic            misalign_q;

    logic            rd_taken;
    logic [XLEN-1:0] rd_target;
    logic            rd_misalign;

    fetch_target_calc #(.XLEN(XLEN)) u_target_calc (
        .redirect_valid (redirect_valid_i),
        .nextpc_sel     (nextpc_sel_i),
        .branch_taken   (branch_taken_i),
        .pc_ex          (pc_ex_i),
        .imm            (imm_i),
        .rs1            (rs1_i),
        .taken          (rd_taken),
        .target         (rd_target),
        .misalign       (rd_misalign)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FS_IDLE;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            instr_q    <= '0;
            pc_out_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            misalign_q <= rd_misalign;
            if (capture) begin
                instr_q  <= imem_rdata_i;
                pc_out_q <= pc_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        capture = 1'b0;
        case (state_q)
            FS_IDLE: state_d = FS_REQ;
            FS_REQ: begin
                if (imem_gnt_i) begin
                    state_d = FS_WAIT;
                    // The granted address is stale once a redirect lands with gnt.
                    if (rd_taken) kill_d = 1'b1;
                end
            end
            FS_WAIT: begin
                if (imem_rvalid_i) begin
                    if (kill_q || rd_taken) begin
                        state_d = FS_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        capture = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                        state_d = FS_VALID;
                    end
                end else if (rd_taken) begin
                    kill_d = 1'b1;
                end
            end
            FS_VALID: begin
                if (rd_taken || instr_ready_i) state_d = FS_REQ;
            end
            default: state_d = FS_IDLE;
        endcase
        if (rd_taken) pc_d = rd_target;
    end

    assign imem_req_o    = (state_q == FS_REQ);
    assign imem_addr_o   = imem_req_o ? pc_q : '0;
    assign instr_valid_o = (state_q == FS_VALID);
    assign instr_o       = instr_q;
    assign opcode_o      = instr_q[OPCODE_W-1:0];
    assign pc_o          = pc_out_q;
    assign misalign_o    = misalign_q;

    a_addr_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_addr_o[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard queue holds instructions that
// decode must eventually accept; a monitor pops and compares on each accept.
module tb_fetch_unit;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        instr_valid_o, instr_ready_i;
    logic [31:0] instr_o, pc_o;
    logic [6:0]  opcode_o;
    logic        redirect_valid_i, branch_taken_i, misalign_o;
    logic [1:0]  nextpc_sel_i;
    logic [31:0] pc_ex_i, imm_i, rs1_i;

    typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;
    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .opcode_o(opcode_o), .pc_o(pc_o),
        .redirect_valid_i(redirect_valid_i), .nextpc_sel_i(nextpc_sel_i),
        .branch_taken_i(branch_taken_i), .pc_ex_i(pc_ex_i), .imm_i(imm_i), .rs1_i(rs1_i),
        .misalign_o(misalign_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor samples just after the negedge, once the bench has set ready for the cycle.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && instr_valid_o && instr_ready_i) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_accept: got pc %h expected no accept", pc_o);
            end else begin
                e = exp_q.pop_front();
                chk("accept_instr", instr_o, e.instr);
                chk("accept_pc", pc_o, e.pc);
                chk("accept_opcode", {25'd0, opcode_o}, {25'd0, e.instr[6:0]});
            end
        end
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_req"}, {31'd0, imem_req_o}, 0);
        chk({nm, "_addr"}, imem_addr_o, 0);
        chk({nm, "_valid"}, {31'd0, instr_valid_o}, 0);
        chk({nm, "_instr"}, instr_o, 0);
        chk({nm, "_opcode"}, {25'd0, opcode_o}, 0);
        chk({nm, "_pc"}, pc_o, 0);
        chk({nm, "_misalign"}, {31'd0, misalign_o}, 0);
    endtask

    task automatic wait_req(input string nm, input logic [31:0] a);
        for (int i = 0; i < 50 && !imem_req_o; i++) @(negedge clk);
        chk({nm, "_req"}, {31'd0, imem_req_o}, 1);
        chk({nm, "_addr"}, imem_addr_o, a);
    endtask

    // Grants in the REQ cycle, returns rvalid next cycle; ends at the first VALID negedge.
    task automatic fetch(input string nm, input logic [31:0] d, input logic [31:0] a, input bit push);
        wait_req(nm, a);
        imem_gnt_i = 1'b1;
        if (push) exp_q.push_back('{d, a});
        @(negedge clk);
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = d;
        @(negedge clk);
        imem_rvalid_i = 1'b0;
        chk({nm, "_latency_valid"}, {31'd0, instr_valid_o}, 1);
        chk({nm, "_pc"}, pc_o, a);
    endtask

    task automatic redirect(input logic [1:0] sel, input logic tk,
                            input logic [31:0] pcx, input logic [31:0] im, input logic [31:0] r1);
        redirect_valid_i = 1'b1;
        nextpc_sel_i     = sel;
        branch_taken_i   = tk;
        pc_ex_i          = pcx;
        imm_i            = im;
        rs1_i            = r1;
    endtask

    initial begin
        rst_n = 1'b0;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0; instr_ready_i = 1;
        redirect_valid_i = 0; nextpc_sel_i = 0; branch_taken_i = 0;
        pc_ex_i = 0; imm_i = 0; rs1_i = 0;

        // reset and first fetch
        @(negedge clk); @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        fetch("first", 32'h0000_0033, 32'h0, 1);

        // decode stalls for 5 cycles
        fetch("stall", 32'h0040_0093, 32'h4, 1);
        instr_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_instr", instr_o, 32'h0040_0093);
            chk("stall_pc", pc_o, 32'h4);
            chk("stall_noreq", {31'd0, imem_req_o}, 0);
        end
        @(negedge clk);
        instr_ready_i = 1'b1;
        chk("ready_cycle_noreq", {31'd0, imem_req_o}, 0);
        @(negedge clk);
        chk("after_ready_req", {31'd0, imem_req_o}, 1);

        // jal redirect while waiting for rvalid
        wait_req("wait_redir", 32'h8);
        imem_gnt_i = 1'b1;
        @(negedge clk);
        imem_gnt_i = 1'b0;
        redirect(2'b10, 1'b0, 32'h100, 32'h20, 32'h0);
        @(negedge clk);
        redirect_valid_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid_i = 1'b0;
        chk("killed_valid", {31'd0, instr_valid_o}, 0);
        chk("killed_refetch_addr", imem_addr_o, 32'h120);

        // not-taken branch during VALID has no effect
        instr_ready_i = 1'b0;
        fetch("nt", 32'h0000_0013, 32'h120, 1);
        redirect(2'b01, 1'b0, 32'h300, 32'h4, 32'h0);
        @(negedge clk);
        redirect_valid_i = 1'b0;
        chk("nt_valid_held", {31'd0, instr_valid_o}, 1);
        chk("nt_pc_held", pc_o, 32'h120);
        instr_ready_i = 1'b1;
        @(negedge clk);
        chk("nt_seq_addr", imem_addr_o, 32'h124);

        // taken branch during VALID drops the instruction
        instr_ready_i = 1'b0;
        fetch("tk", 32'h0000_0063, 32'h124, 0);
        redirect(2'b01, 1'b1, 32'h124, 32'h40, 32'h0);
        @(negedge clk);
        redirect_valid_i = 1'b0;
        chk("tk_valid_drop", {31'd0, instr_valid_o}, 0);
        chk("tk_target_addr", imem_addr_o, 32'h164);

        // jalr in VALID with ready high: accepted, misaligned target
        instr_ready_i = 1'b1;
        fetch("jalr", 32'h0000_80E7, 32'h164, 1);
        redirect(2'b11, 1'b0, 32'h0, 32'h0, 32'h203);
        @(negedge clk);
        chk("jalr_misalign_pulse", {31'd0, misalign_o}, 1);
        chk("jalr_valid_drop", {31'd0, instr_valid_o}, 0);
        chk("jalr_addr", imem_addr_o, 32'h200);
        redirect(2'b11, 1'b0, 32'h0, 32'h0, 32'h201);
        @(negedge clk);
        redirect_valid_i = 1'b0;
        chk("jalr_no_pulse", {31'd0, misalign_o}, 0);
        chk("jalr_addr2", imem_addr_o, 32'h200);

        // redirect in REQ with gnt the same cycle
        redirect(2'b10, 1'b0, 32'h200, 32'h3F0, 32'h0);
        imem_gnt_i = 1'b1;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h1111_1111;
        @(negedge clk);
        imem_rvalid_i = 1'b0;
        chk("gnt_redir_valid", {31'd0, instr_valid_o}, 0);
        chk("gnt_redir_addr", imem_addr_o, 32'h5F0);

        // PC wraps from the top word to zero
        redirect(2'b10, 1'b0, 32'hFFFF_FFF0, 32'hC, 32'h0);
        @(negedge clk);
        redirect_valid_i = 1'b0;
        fetch("wrap_top", 32'h0010_0073, 32'hFFFF_FFFC, 1);
        wait_req("wrap", 32'h0);

        // reset mid-transaction, late rvalid ignored
        imem_gnt_i = 1'b1;
        @(negedge clk);
        imem_gnt_i = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0000_0BAD;
        @(negedge clk);
        imem_rvalid_i = 1'b0;
        chk("late_rvalid_valid", {31'd0, instr_valid_o}, 0);
        chk("late_rvalid_instr", instr_o, 32'h0);
        chk("restart_addr", imem_addr_o, 32'h0);
        fetch("restart", 32'h00A0_0513, 32'h0, 1);

        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that produces the instruction stream whose opcode field feeds the control unit. It owns the PC and issues one outstanding request at a time to instruction memory over a req/gnt/rvalid handshake. It presents a registered instruction, PC and opcode to decode over a valid/ready handshake. It consumes the next-PC select encoding, branch outcome and immediates from execute to redirect fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
XLEN, 32, address and data width.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  reset, asynchronous, active-low.
imem_req_o  out  1  request to instruction memory.
imem_addr_o  out  XLEN  fetch address; word-aligned.
imem_gnt_i  in  1  request accepted this cycle.
imem_rvalid_i  in  1  read data valid; at earliest 1 cycle after gnt.
imem_rdata_i  in  32  instruction word.
instr_valid_o  out  1  instruction available to decode.
instr_ready_i  in  1  decode accepts this cycle.
instr_o  out  32  fetched instruction.
opcode_o  out  7  instr_o[6:0].
pc_o  out  XLEN  address of instr_o.
redirect_valid_i  in  1  execute resolving a control-flow instruction.
nextpc_sel_i  in  2  00 seq, 01 branch, 10 jal, 11 jalr.
branch_taken_i  in  1  branch outcome; used only for sel 01.
pc_ex_i  in  XLEN  PC of the resolving instruction.
imm_i  in  XLEN  sign-extended immediate.
rs1_i  in  XLEN  rs1 value, for jalr.
misalign_o  out  1  one-cycle pulse: redirect target had bit1 set.

Behaviour:
- Reset (rst_ni low, async): pc_q=RESET_PC, state=IDLE, kill=0. All outputs are 0.
- States: IDLE, REQ, WAIT, VALID.
- IDLE: always goes to REQ on the next cycle.
- REQ: imem_req_o=1, imem_addr_o=pc_q.
  - On gnt, go to WAIT.
  - The address may change before gnt, only because of a redirect.
- WAIT: imem_req_o=0.
  - On rvalid with kill=0: register instr_o=rdata and pc_o=pc_q, set pc_q=pc_q+4 (mod 2^32), go to VALID.
  - On rvalid with kill=1: discard the data, clear kill, go to REQ.
- VALID: instr_valid_o=1. instr_o, pc_o and opcode_o are held stable until instr_valid_o && instr_ready_i.
  - On that handshake, go to REQ on the next cycle.
  - Gap between accepted instructions is at least 3 cycles (REQ/gnt, rvalid, VALID).
- Latency: gnt in cycle N and rvalid in cycle N+1 give instr_valid_o in cycle N+2.
- Redirect is taken when redirect_valid_i && (sel==10 || sel==11 || (sel==01 && branch_taken_i)). sel==00, or 01 with not-taken, has no effect.
- Target calculation:
  - sel 01/10: pc_ex_i+imm_i.
  - sel 11: (rs1_i+imm_i) & ~1.
  - If target[1]==1: misalign_o pulses on the next cycle, and pc_q loads the target with [1:0] cleared.
- On a taken redirect, pc_q is set to the target, and then per state:
  - IDLE/REQ without gnt: stay in REQ with the new address.
  - REQ with gnt in the same cycle: go to WAIT with kill=1.
  - WAIT without rvalid: set kill=1.
  - WAIT with rvalid in the same cycle: discard the data, go to REQ.
  - VALID: instr_valid_o drops on the next cycle, go to REQ. If instr_ready_i is high in the same cycle, the instruction counts as accepted.
- Redirect has priority over sequential pc_q+4.
- Only one outstanding imem transaction at a time. rvalid outside WAIT is ignored.
- Reset mid-transaction: the state machine returns to IDLE immediately. A late rvalid after reset arrives outside WAIT and is ignored.

Decomposition:
- Shared package (core_pkg): nextpc_sel_e enum with NPC_SEQ=2'b00, NPC_BRANCH=2'b01, NPC_JAL=2'b10, NPC_JALR=2'b11. The control unit's nextPCsel encoding is redefined on this enum. Also holds the fetch_state_e enum and the OPCODE_W=7 constant.
- One sub-module: fetch_target_calc, combinational. It computes the taken flag, the target and the misalign flag.

Test Plan:
- Reset release, imem gnt same cycle and rvalid next with rdata 32'h00000033 -> imem_addr_o=0, instr_valid_o 2 cycles after gnt, opcode_o=7'b0110011, pc_o=0, next request addr=4.
- instr_ready_i held low 5 cycles -> instr_o/pc_o stable. No imem_req_o until the cycle after ready rises.
- Redirect sel=10, pc_ex_i=0x100, imm_i=0x20 during WAIT, then rvalid -> data discarded, instr_valid_o stays 0, next imem_addr_o=0x120.
- sel=01, branch_taken_i=0 during VALID -> no change, sequential fetch continues. Same with taken=1 -> instr_valid_o drops, fetch at target.
- sel=11, rs1_i=0x203, imm_i=0 -> misalign_o pulses once, fetch addr=0x200. rs1_i=0x201 -> no pulse, addr=0x200.
- pc_q=32'hFFFF_FFFC sequential fetch -> next addr 0x0000_0000. Assert rst_ni low while in WAIT -> outputs 0 immediately, later rvalid ignored, fetch restarts at RESET_PC.
